apb_xfer_master: RTL and testbench

Parametrised APB4 master that turns a valid/ready request channel into single APB transfers across NUM_SLV slaves and returns the outcome on a valid/ready response channel. It decodes the slave from the upper address bits, drives PSTRB, returns slave PSLVERR, and aborts hung transfers with a wait-state timeout. It sits between an internal command source (CPU bridge, test sequencer) and the APB fabric, replacing the fixed two-slave master with its static PSEL input.

---
 rtl/apb_pkg.sv | 24 ++
 rtl/apb_addr_decode.sv | 23 ++
 rtl/apb_xfer_master.sv | 150 +++++++++++++++
 tb/tb_apb_xfer_master.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB master types: FSM state and the cause of an error response.
// Both are visible on debug ports only.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_e;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_SLVERR,
    ERR_DECERR,
    ERR_TIMEOUT
  } apb_err_e;

  // Wait counter width; a disabled timeout still needs a legal 1-bit vector.
  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Maps the upper address bits to a slave index and one-hot select.
// Purely combinational so the interconnect can share it.
module apb_addr_decode #(
  parameter int ADDR_WIDTH = 8,
  parameter int SEL_BITS   = 2,
  parameter int NUM_SLV    = 4
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [SEL_BITS-1:0]   idx,
  output logic [NUM_SLV-1:0]    sel,
  output logic                  out_of_range
);

  always_comb begin
    idx          = addr[ADDR_WIDTH-1 -: SEL_BITS];
    out_of_range = (32'(idx) >= NUM_SLV);
    sel          = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      sel[k] = !out_of_range && (idx == SEL_BITS'(k));
    end
  end

endmodule

// File: rtl/apb_xfer_master.sv
// APB4 master: one valid/ready request becomes one APB transfer to the decoded
// slave, and its outcome is returned on a valid/ready response channel.
module apb_xfer_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLV    = 4,
  parameter int SEL_BITS   = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                          PCLK_i,
  input  logic                          PRESET_i,
  input  logic                          REQ_VALID_i,
  output logic                          REQ_READY_o,
  input  logic                          REQ_WRITE_i,
  input  logic [ADDR_WIDTH-1:0]         REQ_ADDR_i,
  input  logic [DATA_WIDTH-1:0]         REQ_WDATA_i,
  input  logic [DATA_WIDTH/8-1:0]       REQ_STRB_i,
  output logic                          RSP_VALID_o,
  input  logic                          RSP_READY_i,
  output logic [DATA_WIDTH-1:0]         RSP_RDATA_o,
  output logic                          RSP_ERR_o,
  output logic [NUM_SLV-1:0]            PSEL_o,
  output logic                          PENABLE_o,
  output logic                          PWRITE_o,
  output logic [ADDR_WIDTH-1:0]         PADDR_o,
  output logic [DATA_WIDTH-1:0]         PWDATA_o,
  output logic [DATA_WIDTH/8-1:0]       PSTRB_o,
  input  logic [NUM_SLV-1:0]            PREADY_i,
  input  logic [NUM_SLV*DATA_WIDTH-1:0] PRDATA_i,
  input  logic [NUM_SLV-1:0]            PSLVERR_i,
  output apb_state_e                    dbg_state_o,
  output apb_err_e                      dbg_cause_o
);

  // Handshakes: a request transfers on a cycle where REQ_VALID_i && REQ_READY_o,
  // a response on a cycle where RSP_VALID_o && RSP_READY_i. Valid, once raised,
  // holds its payload stable until the transfer cycle.

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  apb_state_e            state_q;
  apb_err_e              cause_q;
  logic [SEL_BITS-1:0]   idx_q;
  logic [CW-1:0]         cnt_q;

  logic [SEL_BITS-1:0]   dec_idx;
  logic [NUM_SLV-1:0]    dec_sel;
  logic                  dec_oor;
  logic                  sel_ready;
  logic                  sel_slverr;
  logic [DATA_WIDTH-1:0] sel_rdata;

  apb_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .SEL_BITS   (SEL_BITS),
    .NUM_SLV    (NUM_SLV)
  ) u_decode (
    .addr         (REQ_ADDR_i),
    .idx          (dec_idx),
    .sel          (dec_sel),
    .out_of_range (dec_oor)
  );

  // Only the captured slave's return signals are ever looked at.
  assign sel_ready   = PREADY_i[idx_q];
  assign sel_slverr  = PSLVERR_i[idx_q];
  assign sel_rdata   = PRDATA_i[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];

  assign REQ_READY_o = (state_q == IDLE);
  assign dbg_state_o = state_q;
  assign dbg_cause_o = cause_q;

  always_ff @(posedge PCLK_i or negedge PRESET_i) begin
    if (!PRESET_i) begin
      state_q     <= IDLE;
      cause_q     <= ERR_NONE;
      idx_q       <= '0;
      cnt_q       <= '0;
      RSP_VALID_o <= 1'b0;
      RSP_RDATA_o <= '0;
      RSP_ERR_o   <= 1'b0;
      PSEL_o      <= '0;
      PENABLE_o   <= 1'b0;
      PWRITE_o    <= 1'b0;
      PADDR_o     <= '0;
      PWDATA_o    <= '0;
      PSTRB_o     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (REQ_VALID_i) begin
            idx_q <= dec_idx;
            if (dec_oor) begin
              // No APB cycle for an unmapped slave; answer straight away.
              RSP_VALID_o <= 1'b1;
              RSP_RDATA_o <= '0;
              RSP_ERR_o   <= 1'b1;
              cause_q     <= ERR_DECERR;
              state_q     <= RESP;
            end else begin
              PWRITE_o <= REQ_WRITE_i;
              PADDR_o  <= REQ_ADDR_i;
              PWDATA_o <= REQ_WDATA_i;
              PSTRB_o  <= REQ_WRITE_i ? REQ_STRB_i : '0;
              PSEL_o   <= dec_sel;
              state_q  <= SETUP;
            end
          end
        end
        SETUP: begin
          PENABLE_o <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (sel_ready) begin
            RSP_VALID_o <= 1'b1;
            RSP_RDATA_o <= (!PWRITE_o && !sel_slverr) ? sel_rdata : '0;
            RSP_ERR_o   <= sel_slverr;
            cause_q     <= sel_slverr ? ERR_SLVERR : ERR_NONE;
            PSEL_o      <= '0;
            PENABLE_o   <= 1'b0;
            state_q     <= RESP;
          end else if (TIMEOUT > 0 && cnt_q == TO_LAST) begin
            RSP_VALID_o <= 1'b1;
            RSP_RDATA_o <= '0;
            RSP_ERR_o   <= 1'b1;
            cause_q     <= ERR_TIMEOUT;
            PSEL_o      <= '0;
            PENABLE_o   <= 1'b0;
            state_q     <= RESP;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          if (RSP_READY_i) begin
            RSP_VALID_o <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_xfer_master.sv
// Directed bench for apb_xfer_master: a 4-slave instance for the main scenarios
// and a 3-slave instance for the unmapped-slave decode error.
module tb_apb_xfer_master;
  import apb_pkg::*;

  logic        pclk = 1'b0;
  logic        preset_n = 1'b0;
  int          tests_run = 0;
  int          fail_cnt = 0;

  // 4-slave instance
  logic        req_valid = 0, req_write = 0, rsp_ready = 0;
  logic [7:0]  req_addr = 0, req_wdata = 0;
  logic [0:0]  req_strb = 0;
  logic        req_ready, rsp_valid, rsp_err, penable, pwrite;
  logic [7:0]  rsp_rdata, paddr, pwdata;
  logic [0:0]  pstrb;
  logic [3:0]  psel;
  logic [3:0]  pready = 0, pslverr = 0;
  logic [31:0] prdata = 0;
  apb_state_e  dbg_state;
  apb_err_e    dbg_cause;

  // 3-slave instance
  logic        req3_valid = 0, req3_write = 0, rsp3_ready = 0;
  logic [7:0]  req3_addr = 0, req3_wdata = 0;
  logic [0:0]  req3_strb = 0;
  logic        req3_ready, rsp3_valid, rsp3_err, penable3, pwrite3;
  logic [7:0]  rsp3_rdata, paddr3, pwdata3;
  logic [0:0]  pstrb3;
  logic [2:0]  psel3;
  logic [2:0]  pready3 = 3'b111, pslverr3 = 0;
  logic [23:0] prdata3 = 24'h112233;
  apb_state_e  dbg_state3;
  apb_err_e    dbg_cause3;

  apb_xfer_master #(.NUM_SLV(4)) dut (
    .PCLK_i(pclk), .PRESET_i(preset_n),
    .REQ_VALID_i(req_valid), .REQ_READY_o(req_ready), .REQ_WRITE_i(req_write),
    .REQ_ADDR_i(req_addr), .REQ_WDATA_i(req_wdata), .REQ_STRB_i(req_strb),
    .RSP_VALID_o(rsp_valid), .RSP_READY_i(rsp_ready), .RSP_RDATA_o(rsp_rdata),
    .RSP_ERR_o(rsp_err), .PSEL_o(psel), .PENABLE_o(penable), .PWRITE_o(pwrite),
    .PADDR_o(paddr), .PWDATA_o(pwdata), .PSTRB_o(pstrb), .PREADY_i(pready),
    .PRDATA_i(prdata), .PSLVERR_i(pslverr),
    .dbg_state_o(dbg_state), .dbg_cause_o(dbg_cause)
  );

  apb_xfer_master #(.NUM_SLV(3)) dut3 (
    .PCLK_i(pclk), .PRESET_i(preset_n),
    .REQ_VALID_i(req3_valid), .REQ_READY_o(req3_ready), .REQ_WRITE_i(req3_write),
    .REQ_ADDR_i(req3_addr), .REQ_WDATA_i(req3_wdata), .REQ_STRB_i(req3_strb),
    .RSP_VALID_o(rsp3_valid), .RSP_READY_i(rsp3_ready), .RSP_RDATA_o(rsp3_rdata),
    .RSP_ERR_o(rsp3_err), .PSEL_o(psel3), .PENABLE_o(penable3), .PWRITE_o(pwrite3),
    .PADDR_o(paddr3), .PWDATA_o(pwdata3), .PSTRB_o(pstrb3), .PREADY_i(pready3),
    .PRDATA_i(prdata3), .PSLVERR_i(pslverr3),
    .dbg_state_o(dbg_state3), .dbg_cause_o(dbg_cause3)
  );

  // Clock and reset
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
    $fatal(1, "watchdog");
  end

  // Driver tasks: all stimulus changes happen at the falling edge.
  task automatic drive_req(input logic w, input logic [7:0] a, input logic [7:0] d,
                           input logic [0:0] s);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_strb = s;
  endtask

  task automatic drop_req();
    req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00; req_strb = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    tests_run++; if (req_ready !== 1'b1) begin fail_cnt++; $display("FAIL rst_req_ready: got %b exp 1", req_ready); end
    tests_run++; if (psel !== 4'b0000 || penable !== 1'b0) begin fail_cnt++; $display("FAIL rst_psel_penable: got %b/%b exp 0000/0", psel, penable); end
    tests_run++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 8'h00) begin fail_cnt++; $display("FAIL rst_rsp: got v%b e%b d%h exp 0/0/00", rsp_valid, rsp_err, rsp_rdata); end
    tests_run++; if (paddr !== 8'h00 || pwdata !== 8'h00 || pstrb !== 1'b0 || pwrite !== 1'b0) begin fail_cnt++; $display("FAIL rst_apb_bus: got a%h d%h s%b w%b exp zeros", paddr, pwdata, pstrb, pwrite); end
    @(negedge pclk); preset_n = 1'b1;
    @(negedge pclk);
  endtask

  task automatic test_write_zero_wait();
    pready = 4'b1111; rsp_ready = 1'b1;
    drive_req(1'b1, 8'h47, 8'hA5, 1'b1);
    tests_run++; if (req_ready !== 1'b1) begin fail_cnt++; $display("FAIL wr_req_ready_c0: got %b exp 1", req_ready); end
    @(negedge pclk); drop_req();
    tests_run++; if (psel !== 4'b0010 || penable !== 1'b0) begin fail_cnt++; $display("FAIL wr_setup_c1: got psel %b pen %b exp 0010/0", psel, penable); end
    tests_run++; if (paddr !== 8'h47 || pwdata !== 8'hA5 || pstrb !== 1'b1 || pwrite !== 1'b1) begin fail_cnt++; $display("FAIL wr_bus_c1: got a%h d%h s%b w%b exp 47/a5/1/1", paddr, pwdata, pstrb, pwrite); end
    tests_run++; if (req_ready !== 1'b0) begin fail_cnt++; $display("FAIL wr_req_ready_c1: got %b exp 0", req_ready); end
    @(negedge pclk);
    tests_run++; if (psel !== 4'b0010 || penable !== 1'b1) begin fail_cnt++; $display("FAIL wr_access_c2: got psel %b pen %b exp 0010/1", psel, penable); end
    @(negedge pclk);
    tests_run++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 8'h00) begin fail_cnt++; $display("FAIL wr_rsp_c3: got v%b e%b d%h exp 1/0/00", rsp_valid, rsp_err, rsp_rdata); end
    tests_run++; if (psel !== 4'b0000 || penable !== 1'b0) begin fail_cnt++; $display("FAIL wr_idle_bus_c3: got psel %b pen %b exp 0000/0", psel, penable); end
    @(negedge pclk);
    tests_run++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin fail_cnt++; $display("FAIL wr_done_c4: got rdy %b v %b exp 1/0", req_ready, rsp_valid); end
    tests_run++; if (paddr !== 8'h47 || pwdata !== 8'hA5) begin fail_cnt++; $display("FAIL wr_bus_hold_c4: got a%h d%h exp 47/a5", paddr, pwdata); end
    pready = 4'b0000; rsp_ready = 1'b0;
  endtask

  task automatic test_read_wait();
    pready = 4'b0000; pslverr = 4'b0001; prdata = 32'hFF_FF_FF_FF; rsp_ready = 1'b0;
    drive_req(1'b0, 8'hC3, 8'h99, 1'b1);
    @(negedge pclk); drop_req();
    tests_run++; if (psel !== 4'b1000 || pstrb !== 1'b0 || pwrite !== 1'b0) begin fail_cnt++; $display("FAIL rd_setup_c1: got psel %b s%b w%b exp 1000/0/0", psel, pstrb, pwrite); end
    @(negedge pclk);
    tests_run++; if (penable !== 1'b1 || rsp_valid !== 1'b0) begin fail_cnt++; $display("FAIL rd_wait1_c2: got pen %b v %b exp 1/0", penable, rsp_valid); end
    @(negedge pclk);
    tests_run++; if (penable !== 1'b1 || rsp_valid !== 1'b0 || pstrb !== 1'b0) begin fail_cnt++; $display("FAIL rd_wait2_c3: got pen %b v %b s %b exp 1/0/0", penable, rsp_valid, pstrb); end
    @(negedge pclk);
    tests_run++; if (penable !== 1'b1 || psel !== 4'b1000) begin fail_cnt++; $display("FAIL rd_access_c4: got pen %b psel %b exp 1/1000", penable, psel); end
    pready = 4'b1000; prdata = {8'h5A, 8'hFF, 8'hFF, 8'hFF};
    @(negedge pclk);
    pready = 4'b0000;
    tests_run++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h5A || rsp_err !== 1'b0) begin fail_cnt++; $display("FAIL rd_rsp_c5: got v%b d%h e%b exp 1/5a/0", rsp_valid, rsp_rdata, rsp_err); end
    rsp_ready = 1'b1;
    @(negedge pclk);
    tests_run++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin fail_cnt++; $display("FAIL rd_done_c6: got rdy %b v %b exp 1/0", req_ready, rsp_valid); end
    rsp_ready = 1'b0; pslverr = 4'b0000; prdata = 32'h0;
  endtask

  task automatic test_decode_error();
    req3_valid = 1'b1; req3_write = 1'b0; req3_addr = 8'hC0; rsp3_ready = 1'b0;
    @(negedge pclk); req3_valid = 1'b0;
    tests_run++; if (rsp3_valid !== 1'b1 || rsp3_err !== 1'b1 || rsp3_rdata !== 8'h00) begin fail_cnt++; $display("FAIL dec_rsp_c1: got v%b e%b d%h exp 1/1/00", rsp3_valid, rsp3_err, rsp3_rdata); end
    tests_run++; if (psel3 !== 3'b000 || penable3 !== 1'b0) begin fail_cnt++; $display("FAIL dec_no_apb_c1: got psel %b pen %b exp 000/0", psel3, penable3); end
    tests_run++; if (dbg_cause3 !== ERR_DECERR) begin fail_cnt++; $display("FAIL dec_cause: got %0d exp %0d", dbg_cause3, ERR_DECERR); end
    rsp3_ready = 1'b1;
    @(negedge pclk);
    tests_run++; if (req3_ready !== 1'b1) begin fail_cnt++; $display("FAIL dec_idle_c2: got %b exp 1", req3_ready); end
    // Highest mapped slave on the 3-slave instance still works.
    req3_valid = 1'b1; req3_addr = 8'h80;
    @(negedge pclk); req3_valid = 1'b0;
    tests_run++; if (psel3 !== 3'b100) begin fail_cnt++; $display("FAIL dec_slv2_setup: got %b exp 100", psel3); end
    @(negedge pclk); @(negedge pclk);
    tests_run++; if (rsp3_valid !== 1'b1 || rsp3_err !== 1'b0 || rsp3_rdata !== 8'h11) begin fail_cnt++; $display("FAIL dec_slv2_rsp: got v%b e%b d%h exp 1/0/11", rsp3_valid, rsp3_err, rsp3_rdata); end
    @(negedge pclk); rsp3_ready = 1'b0;
  endtask

  // ready_at = 0 keeps PREADY low throughout; otherwise it rises in that ACCESS cycle.
  task automatic run_timeout(input int ready_at, input logic exp_err, input logic [7:0] exp_rdata,
                             input string name);
    int acc_cycles = 0;
    logic seen = 1'b0;
    pready = 4'b0000; prdata = {4{8'h33}}; rsp_ready = 1'b0;
    drive_req(1'b0, 8'h05, 8'h00, 1'b0);
    @(negedge pclk); drop_req();
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge pclk);
      if (rsp_valid) seen = 1'b1;
      else if (penable) begin
        acc_cycles++;
        if (acc_cycles == ready_at) pready = 4'b0001;
      end
    end
    pready = 4'b0000;
    tests_run++; if (!seen) begin fail_cnt++; $display("FAIL %s_rsp_seen: got none exp response within 40 cycles", name); end
    tests_run++; if (acc_cycles != 16) begin fail_cnt++; $display("FAIL %s_access_len: got %0d exp 16", name, acc_cycles); end
    tests_run++; if (rsp_err !== exp_err || rsp_rdata !== exp_rdata) begin fail_cnt++; $display("FAIL %s_rsp: got e%b d%h exp %b/%h", name, rsp_err, rsp_rdata, exp_err, exp_rdata); end
    tests_run++; if (dbg_cause !== (exp_err ? ERR_TIMEOUT : ERR_NONE)) begin fail_cnt++; $display("FAIL %s_cause: got %0d", name, dbg_cause); end
    rsp_ready = 1'b1;
    @(negedge pclk); rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    run_timeout(0, 1'b1, 8'h00, "to_hung");
    run_timeout(16, 1'b0, 8'h33, "to_ready_wins");
  endtask

  task automatic test_slverr_backpressure();
    pready = 4'b0100; pslverr = 4'b0100; rsp_ready = 1'b0;
    drive_req(1'b1, 8'h85, 8'h3C, 1'b1);
    @(negedge pclk); drop_req();
    @(negedge pclk); @(negedge pclk);
    tests_run++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 8'h00) begin fail_cnt++; $display("FAIL se_rsp_c3: got v%b e%b d%h exp 1/1/00", rsp_valid, rsp_err, rsp_rdata); end
    pready = 4'b0000; pslverr = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      tests_run++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 8'h00 || req_ready !== 1'b0) begin fail_cnt++; $display("FAIL se_hold_%0d: got v%b e%b d%h rdy%b exp 1/1/00/0", i, rsp_valid, rsp_err, rsp_rdata, req_ready); end
    end
    rsp_ready = 1'b1;
    @(negedge pclk);
    tests_run++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin fail_cnt++; $display("FAIL se_release: got rdy %b v %b exp 1/0", req_ready, rsp_valid); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    pready = 4'b0000; rsp_ready = 1'b1;
    drive_req(1'b0, 8'h40, 8'h00, 1'b0);
    @(negedge pclk); drop_req();
    @(negedge pclk);
    tests_run++; if (penable !== 1'b1 || dbg_state !== ACCESS) begin fail_cnt++; $display("FAIL rm_in_access: got pen %b st %0d exp 1/%0d", penable, dbg_state, ACCESS); end
    #2 preset_n = 1'b0;
    #1;
    tests_run++; if (psel !== 4'b0000 || penable !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin fail_cnt++; $display("FAIL rm_async_drop: got psel %b pen %b v %b rdy %b exp 0000/0/0/1", psel, penable, rsp_valid, req_ready); end
    tests_run++; if (paddr !== 8'h00) begin fail_cnt++; $display("FAIL rm_paddr: got %h exp 00", paddr); end
    @(negedge pclk); preset_n = 1'b1;
    @(negedge pclk);
    pready = 4'b0010;
    drive_req(1'b1, 8'h41, 8'h77, 1'b1);
    @(negedge pclk); drop_req();
    tests_run++; if (psel !== 4'b0010 || pwdata !== 8'h77) begin fail_cnt++; $display("FAIL rm_after_setup: got psel %b d %h exp 0010/77", psel, pwdata); end
    @(negedge pclk); @(negedge pclk);
    tests_run++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin fail_cnt++; $display("FAIL rm_after_rsp: got v%b e%b exp 1/0", rsp_valid, rsp_err); end
    @(negedge pclk);
    pready = 4'b0000; rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_decode_error();
    test_timeout();
    test_slverr_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
